fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Y86-64 pipelined fetch unit; sits directly upstream of the decode pipeline register and drives its f* inputs.
- Owns the predicted-PC register with stall support and selects the fetch PC, including mispredict and ret redirects.
- Drives the instruction-memory port and splits the fetched bytes into icode/ifun/rA/rB/valC.
- Computes valP and the next predicted PC, and holds a halt/exception lock plus a retired-fetch counter.

Parameters:
RESET_PC, 64'h0, predicted-PC value loaded on reset
CNT_W, 32, width of the fetched-instruction counter

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
F_stall  in  1  hold predicted PC and counter this cycle
M_icode  in  4  icode in memory stage
M_cnd  in  1  branch condition in memory stage
M_valA  in  64  fall-through PC of the jump in memory stage
W_icode  in  4  icode in write-back stage
W_valM  in  64  return address read by ret in write-back stage
imem_addr  out  64  fetch address (= f_pc)
imem_data  in  80  10 bytes at imem_addr; byte0 in [7:0], combinational read
imem_error  in  1  fetch address out of range
f_icode, f_ifun, f_rA, f_rB  out  4 each  decoded fields
f_valC  out  64  constant word
f_valP  out  64  address of next sequential instruction
f_stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
f_predPC  out  64  next predicted PC (input of the PC register)
F_predPC  out  64  registered predicted PC
instr_cnt  out  CNT_W  count of accepted fetches

Behaviour:
Reset:
- rst_n low forces F_predPC=RESET_PC, lock=0, instr_cnt=0 immediately.
- While rst_n is low, f_icode=1 (nop), f_ifun=0, f_rA=f_rB=F, f_valC=0, f_stat=AOK.

PC select (combinational, priority order):
1. M_icode==7 && !M_cnd -> M_valA
2. W_icode==9 -> W_valM
3. otherwise F_predPC
- Either redirect (1 or 2) also clears lock in the same cycle.

Split and align:
- byte0 gives icode=[7:4], ifun=[3:0].
- need_regids for icodes 2,3,4,5,6,A,B; when set, byte1 gives rA=[7:4], rB=[3:0]; otherwise rA=rB=F.
- need_valC for icodes 3,4,5,7,8; valC is little-endian from byte1 (no regids) or byte2 (regids); otherwise 0.
- valP = f_pc + 1 + need_regids + 8*need_valC, 64-bit wrap-around (no overflow flag).

Validity and status:
- Valid icodes are 0..B; any other value gives f_stat=INS.
- imem_error gives f_stat=ADR and forces icode=1 (nop); ADR beats INS.
- icode 0 gives f_stat=HLT.

Prediction:
- f_predPC = valC for icode 7 or 8; valP otherwise.

Lock:
- Set on posedge when f_stat is HLT, ADR or INS and !F_stall.
- While lock=1 and no redirect: outputs forced to the nop bubble with f_stat=AOK, F_predPC held, counter held.

Registered update (posedge, lock=0 or redirect):
- If !F_stall: F_predPC <= f_predPC and instr_cnt increments (wraps).
- If F_stall: F_predPC, lock and instr_cnt all hold.

Simultaneous events:
- Mispredict and ret redirect together: mispredict wins.
- Redirect while F_stall: the redirect still drives f_pc combinationally, but F_predPC does not update.

Asynchronous reset mid-operation aborts immediately; no partial state survives.

Test Plan:
- Reset with RESET_PC=0, mem[0]=30 F2 0A 00..00 (irmovq $10,%rdx) -> f_icode=3, f_rB=2, f_valC=10, f_valP=10, f_predPC=10; next edge F_predPC=10, instr_cnt=1.
- mem[0]=70 20 00..00 (jmp 0x20) -> f_predPC=0x20. Later drive M_icode=7, M_cnd=0, M_valA=9 -> imem_addr=9 that cycle.
- ret sequence: W_icode=9, W_valM=0x40 -> imem_addr=0x40. Same cycle with M mispredict to 0x50 -> imem_addr=0x50.
- Fetch of 00 (halt) at PC 4 -> f_stat=2; afterwards outputs nop with F_predPC=5 frozen and instr_cnt frozen until a redirect is applied.
- byte0=0xC0 -> f_stat=4 and lock set; imem_error=1 with the same byte -> f_stat=3, f_icode=1.
- F_stall=1 for 3 cycles -> F_predPC and instr_cnt constant. Assert rst_n=0 between edges -> F_predPC=RESET_PC immediately.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory port between the fetch stage and instruction memory.
// The fetch stage presents an address; memory returns 10 bytes combinationally.
interface fetch_stage_if;
    logic [63:0] imem_addr;
    logic [79:0] imem_data;
    logic        imem_error;

    modport master (
        output imem_addr,
        input  imem_data,
        input  imem_error
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output imem_error
    );
endinterface

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC selection, instruction split/align, valP and
// next-PC prediction, halt/exception lock and an accepted-fetch counter.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             F_stall,
    input  logic [3:0]       M_icode,
    input  logic             M_cnd,
    input  logic [63:0]      M_valA,
    input  logic [3:0]       W_icode,
    input  logic [63:0]      W_valM,
    fetch_stage_if.master    imem,
    output logic [3:0]       f_icode,
    output logic [3:0]       f_ifun,
    output logic [3:0]       f_rA,
    output logic [3:0]       f_rB,
    output logic [63:0]      f_valC,
    output logic [63:0]      f_valP,
    output logic [2:0]       f_stat,
    output logic [63:0]      f_predPC,
    output logic [63:0]      F_predPC,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_NONE   = 4'hF;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic {
        ST_RUN,
        ST_LOCKED
    } state_e;

    state_e            state_q, state_d;
    logic [63:0]       F_predPC_q, F_predPC_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic        mispredict;
    logic        ret_redirect;
    logic        redirect;
    logic [63:0] f_pc;
    logic        bubble;
    logic        advance;

    logic [3:0]  raw_icode;
    logic [3:0]  raw_ifun;
    logic        instr_valid;
    logic [3:0]  fetch_icode;
    logic [3:0]  fetch_ifun;
    logic [2:0]  fetch_stat;
    logic        need_regids;
    logic        need_valC;

    // PC select: memory-stage mispredict outranks a write-back ret.
    always_comb begin
        mispredict   = (M_icode == I_JXX) && !M_cnd;
        ret_redirect = (W_icode == I_RET);
        redirect     = mispredict || ret_redirect;
        if (mispredict) begin
            f_pc = M_valA;
        end else if (ret_redirect) begin
            f_pc = W_valM;
        end else begin
            f_pc = F_predPC_q;
        end
    end

    assign imem.imem_addr = f_pc;

    // Raw decode of byte0 and status classification (ADR > INS > HLT).
    always_comb begin
        raw_icode   = imem.imem_data[7:4];
        raw_ifun    = imem.imem_data[3:0];
        instr_valid = (raw_icode <= I_POPQ);
        fetch_icode = imem.imem_error ? I_NOP : raw_icode;
        fetch_ifun  = imem.imem_error ? 4'h0  : raw_ifun;
        if (imem.imem_error) begin
            fetch_stat = STAT_ADR;
        end else if (!instr_valid) begin
            fetch_stat = STAT_INS;
        end else if (raw_icode == I_HALT) begin
            fetch_stat = STAT_HLT;
        end else begin
            fetch_stat = STAT_AOK;
        end
    end

    // State register: halt/exception lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a redirect overrides the lock; a stall holds everything.
    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = (f_stat != STAT_AOK) ? ST_LOCKED : ST_RUN;
        end
    end

    // Output decode: reset and lock both present the nop bubble.
    always_comb begin
        bubble  = (state_q == ST_LOCKED) && !redirect;
        advance = !F_stall && !bubble;

        f_icode = fetch_icode;
        f_ifun  = fetch_ifun;
        f_stat  = fetch_stat;
        if (!rst_n || bubble) begin
            f_icode = I_NOP;
            f_ifun  = 4'h0;
            f_stat  = STAT_AOK;
        end

        need_regids = (f_icode == I_RRMOVQ) || (f_icode == I_IRMOVQ) ||
                      (f_icode == I_RMMOVQ) || (f_icode == I_MRMOVQ) ||
                      (f_icode == I_OPQ)    || (f_icode == I_PUSHQ)  ||
                      (f_icode == I_POPQ);
        need_valC   = (f_icode == I_IRMOVQ) || (f_icode == I_RMMOVQ) ||
                      (f_icode == I_MRMOVQ) || (f_icode == I_JXX)    ||
                      (f_icode == I_CALL);

        f_rA = R_NONE;
        f_rB = R_NONE;
        if (need_regids) begin
            f_rA = imem.imem_data[15:12];
            f_rB = imem.imem_data[11:8];
        end

        // valC follows the register byte when one is present.
        f_valC = '0;
        if (need_valC) begin
            f_valC = need_regids ? imem.imem_data[79:16] : imem.imem_data[71:8];
        end

        f_valP = f_pc + 64'd1 + {63'd0, need_regids} + (need_valC ? 64'd8 : 64'd0);

        if ((f_icode == I_JXX) || (f_icode == I_CALL)) begin
            f_predPC = f_valC;
        end else begin
            f_predPC = f_valP;
        end
    end

    // Predicted-PC and counter next values: update only on an accepted fetch.
    always_comb begin
        F_predPC_d = F_predPC_q;
        cnt_d      = cnt_q;
        if (advance) begin
            F_predPC_d = f_predPC;
            cnt_d      = cnt_q + CNT_W'(1);
        end
    end

    // Predicted-PC register and accepted-fetch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            F_predPC_q <= RESET_PC;
            cnt_q      <= '0;
        end else begin
            F_predPC_q <= F_predPC_d;
            cnt_q      <= cnt_d;
        end
    end

    assign F_predPC  = F_predPC_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expectations are queued as stimulus is
// applied and drained against the DUT one time unit later.
module tb_fetch_stage;

    typedef enum int {
        S_ICODE, S_IFUN, S_RA, S_RB, S_VALC, S_VALP,
        S_STAT, S_PRED, S_FPRED, S_ADDR, S_CNT
    } sel_e;

    typedef struct {
        string       tag;
        sel_e        sel;
        logic [63:0] exp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        F_stall;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP, f_predPC, F_predPC;
    logic [2:0]  f_stat;
    logic [31:0] instr_cnt;
    logic        err_force;
    logic [7:0]  mem [0:255];

    int   n_vec;
    int   n_miscmp;
    exp_t sb [$];

    fetch_stage_if intf ();

    fetch_stage #(.RESET_PC(64'h0), .CNT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .F_stall   (F_stall),
        .M_icode   (M_icode),
        .M_cnd     (M_cnd),
        .M_valA    (M_valA),
        .W_icode   (W_icode),
        .W_valM    (W_valM),
        .imem      (intf.master),
        .f_icode   (f_icode),
        .f_ifun    (f_ifun),
        .f_rA      (f_rA),
        .f_rB      (f_rB),
        .f_valC    (f_valC),
        .f_valP    (f_valP),
        .f_stat    (f_stat),
        .f_predPC  (f_predPC),
        .F_predPC  (F_predPC),
        .instr_cnt (instr_cnt)
    );

    // Byte-addressed memory; addresses wrap on the low 8 bits.
    always_comb begin
        intf.imem_data = '0;
        for (int i = 0; i < 10; i++) begin
            intf.imem_data[8*i +: 8] = mem[intf.imem_addr[7:0] + 8'(i)];
        end
    end
    assign intf.imem_error = err_force;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input sel_e s);
        case (s)
            S_ICODE: return {60'd0, f_icode};
            S_IFUN:  return {60'd0, f_ifun};
            S_RA:    return {60'd0, f_rA};
            S_RB:    return {60'd0, f_rB};
            S_VALC:  return f_valC;
            S_VALP:  return f_valP;
            S_STAT:  return {61'd0, f_stat};
            S_PRED:  return f_predPC;
            S_FPRED: return F_predPC;
            S_ADDR:  return intf.imem_addr;
            default: return {32'd0, instr_cnt};
        endcase
    endfunction

    task automatic push(input string tag, input sel_e s, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = s;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic clear_redirects();
        M_icode = 4'h1;
        M_cnd   = 1'b1;
        M_valA  = '0;
        W_icode = 4'h1;
        W_valM  = '0;
    endtask

    initial begin
        n_vec     = 0;
        n_miscmp  = 0;
        rst_n     = 1'b0;
        F_stall   = 1'b0;
        err_force = 1'b0;
        clear_redirects();
        for (int i = 0; i < 256; i++) mem[i] = 8'h10;
        // irmovq $10,%rdx at 0
        mem[0] = 8'h30; mem[1] = 8'hF2; mem[2] = 8'h0A;
        for (int i = 3; i < 10; i++) mem[i] = 8'h00;
        // jmp 0x20 at 10
        mem[10] = 8'h70; mem[11] = 8'h20;
        for (int i = 12; i < 19; i++) mem[i] = 8'h00;
        mem[8'h30] = 8'hC0; mem[8'h31] = 8'h00;
        mem[8'hFE] = 8'h60; mem[8'hFF] = 8'h23;

        // Reset: nop bubble and reset state
        #1;
        push("rst_icode", S_ICODE, 64'h1);
        push("rst_ifun",  S_IFUN,  64'h0);
        push("rst_rA",    S_RA,    64'hF);
        push("rst_rB",    S_RB,    64'hF);
        push("rst_valC",  S_VALC,  64'h0);
        push("rst_stat",  S_STAT,  64'h1);
        push("rst_F",     S_FPRED, 64'h0);
        push("rst_cnt",   S_CNT,   64'h0);
        drain();

        // irmovq at PC 0
        @(negedge clk);
        rst_n = 1'b1;
        push("irm_icode", S_ICODE, 64'h3);
        push("irm_rA",    S_RA,    64'hF);
        push("irm_rB",    S_RB,    64'h2);
        push("irm_valC",  S_VALC,  64'd10);
        push("irm_valP",  S_VALP,  64'd10);
        push("irm_pred",  S_PRED,  64'd10);
        push("irm_stat",  S_STAT,  64'h1);
        drain();

        // jmp 0x20 at PC 10
        @(negedge clk);
        push("jmp_F",     S_FPRED, 64'd10);
        push("jmp_cnt",   S_CNT,   64'd1);
        push("jmp_icode", S_ICODE, 64'h7);
        push("jmp_rA",    S_RA,    64'hF);
        push("jmp_valC",  S_VALC,  64'h20);
        push("jmp_valP",  S_VALP,  64'h13);
        push("jmp_pred",  S_PRED,  64'h20);
        drain();

        // Stall three cycles while exercising redirects
        @(negedge clk);
        push("at20_F",   S_FPRED, 64'h20);
        push("at20_cnt", S_CNT,   64'd2);
        drain();
        F_stall = 1'b1;
        M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'd9;
        push("mis_addr",  S_ADDR,  64'd9);
        push("mis_icode", S_ICODE, 64'h0);
        push("mis_stat",  S_STAT,  64'h2);
        drain();

        @(negedge clk);
        push("stl1_F",   S_FPRED, 64'h20);
        push("stl1_cnt", S_CNT,   64'd2);
        drain();
        clear_redirects();
        W_icode = 4'h9; W_valM = 64'h40;
        push("ret_addr", S_ADDR, 64'h40);
        drain();

        @(negedge clk);
        M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h50;
        push("both_addr", S_ADDR,  64'h50);
        push("stl2_F",    S_FPRED, 64'h20);
        push("stl2_cnt",  S_CNT,   64'd2);
        drain();

        @(negedge clk);
        push("stl3_F",   S_FPRED, 64'h20);
        push("stl3_cnt", S_CNT,   64'd2);
        drain();
        F_stall = 1'b0;
        clear_redirects();
        push("unstl_addr", S_ADDR, 64'h20);
        drain();

        // Halt at PC 4 via mispredict redirect
        M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'd4;
        push("hlt_addr", S_ADDR, 64'd4);
        push("hlt_stat", S_STAT, 64'h2);
        push("hlt_icode", S_ICODE, 64'h0);
        push("hlt_valP", S_VALP, 64'd5);
        push("hlt_pred", S_PRED, 64'd5);
        drain();

        @(negedge clk);
        clear_redirects();
        push("lk1_F",     S_FPRED, 64'd5);
        push("lk1_cnt",   S_CNT,   64'd3);
        push("lk1_icode", S_ICODE, 64'h1);
        push("lk1_stat",  S_STAT,  64'h1);
        push("lk1_rA",    S_RA,    64'hF);
        push("lk1_valC",  S_VALC,  64'h0);
        drain();

        @(negedge clk);
        push("lk2_F",     S_FPRED, 64'd5);
        push("lk2_cnt",   S_CNT,   64'd3);
        push("lk2_icode", S_ICODE, 64'h1);
        drain();
        // ret redirect out of the lock into an invalid opcode
        W_icode = 4'h9; W_valM = 64'h30;
        push("ins_addr",  S_ADDR,  64'h30);
        push("ins_stat",  S_STAT,  64'h4);
        push("ins_icode", S_ICODE, 64'hC);
        drain();

        @(negedge clk);
        clear_redirects();
        push("ilk_F",     S_FPRED, 64'h31);
        push("ilk_cnt",   S_CNT,   64'd4);
        push("ilk_stat",  S_STAT,  64'h1);
        push("ilk_icode", S_ICODE, 64'h1);
        drain();
        M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h30;
        err_force = 1'b1;
        push("adr_stat",  S_STAT,  64'h3);
        push("adr_icode", S_ICODE, 64'h1);
        push("adr_valP",  S_VALP,  64'h31);
        drain();

        @(negedge clk);
        err_force = 1'b0;
        push("adr_F",   S_FPRED, 64'h31);
        push("adr_cnt", S_CNT,   64'd5);
        drain();
        // valP wrap-around at the top of the address space
        F_stall = 1'b1;
        M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'hFFFF_FFFF_FFFF_FFFE;
        push("wrap_icode", S_ICODE, 64'h6);
        push("wrap_rA",    S_RA,    64'h2);
        push("wrap_rB",    S_RB,    64'h3);
        push("wrap_valP",  S_VALP,  64'h0);
        drain();

        // Asynchronous reset between edges
        #1;
        rst_n = 1'b0;
        push("arst_F",     S_FPRED, 64'h0);
        push("arst_cnt",   S_CNT,   64'h0);
        push("arst_icode", S_ICODE, 64'h1);
        push("arst_stat",  S_STAT,  64'h1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
